// File: rtl/key_expansion.sv
// key_expansion: AES-128 key schedule generator; latches a key on start and
// derives one round key per clock into a 1408-bit {w0..w43} bus.
module key_expansion (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic          start,
  output logic          finish,
  output logic [1407:0] out
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Rcon byte k sits at byte position k from the left; unused counts map to 0.
  localparam logic [127:0] RCON = 128'h0001020408102040801b360000000000;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          finish_q, finish_d;
  logic [127:0]  rk_q, rk_d;
  logic [1407:0] out_q, out_d;
  logic [31:0]   rot, sub, t, n0, n1, n2, n3;
  logic [127:0]  next_rk;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction
  assign rot     = {rk_q[23:0], rk_q[31:24]};
  assign sub     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign t       = sub ^ {RCON[8*(15-int'(cnt_q)) +: 8], 24'h0};
  assign n0      = rk_q[127:96] ^ t;
  assign n1      = rk_q[95:64] ^ n0;
  assign n2      = rk_q[63:32] ^ n1;
  assign n3      = rk_q[31:0] ^ n2;
  assign next_rk = {n0, n1, n2, n3};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    finish_d = finish_q;
    rk_d     = rk_q;
    out_d    = out_q;
    if (state_q == IDLE) begin
      finish_d = 1'b0;
      if (start) begin
        out_d[1407:1280] = key;
        rk_d             = key;
        cnt_d            = 4'd1;
        state_d          = RUN;
      end
    end else if (state_q == RUN) begin
      for (int r = 1; r <= 10; r++)
        if (cnt_q == 4'(r)) out_d[1407-128*r -: 128] = next_rk;
      rk_d  = next_rk;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd10) begin
        finish_d = 1'b1;
        state_d  = DONE;
      end
    end else if (!start) begin
      finish_d = 1'b0;
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      finish_q <= 1'b0;
      rk_q     <= 128'h0;
      out_q    <= 1408'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      finish_q <= finish_d;
      rk_q     <= rk_d;
      out_q    <= out_d;
    end
  end
  assign finish = finish_q;
  assign out    = out_q;
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: randomized and FIPS-197 checks of key_expansion against a
// model that builds the S-box from GF(2^8) inversion and the affine map.
module tb_key_expansion;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [127:0]  key = 128'h0;
  logic          start = 1'b0;
  logic          finish;
  logic [1407:0] out;
  int            n_vec = 0;
  int            n_err = 0;
  logic [7:0]    sb [256];
  key_expansion dut (.clk(clk), .rst(rst), .key(key), .start(start), .finish(finish), .out(out));
  always #5 clk = ~clk;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = w[i];
    return res;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_sched(input string tag, input logic [127:0] k);
    logic [1407:0] m = expand(k);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("%s rk%0d", tag, r), out[1407-128*r -: 128], m[1407-128*r -: 128]);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " finish"}, 128'(finish), 128'h0);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("%s zero rk%0d", tag, r), out[1407-128*r -: 128], 128'h0);
  endtask
  task automatic wait_fin(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1 cyc++;
    end while (!finish && cyc < 20);
  endtask
  task automatic run(input string tag, input logic [127:0] k);
    int cyc;
    @(negedge clk);
    key   = k;
    start = 1'b1;
    wait_fin(cyc);
    chk({tag, " latency"}, 128'(cyc), 128'd11);
    chk_sched(tag, k);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 chk({tag, " drop"}, 128'(finish), 128'h0);
    chk({tag, " hold rk10"}, out[127:0], expand(k)[127:0]);
  endtask
  initial begin
    logic [127:0] k1, k2;
    int cyc;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h0;
      for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    key   = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk_zero("idle");
    run("a1", 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("a1 fips rk1", out[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1 fips rk10", out[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run("zero", 128'h0);
    chk("zero fips rk0", out[1407:1280], 128'h0);
    chk("zero fips rk1", out[1279:1152], 128'h62636363626363636263636362636363);
    chk("zero fips rk10", out[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    k1 = 128'h657870616e642033322d62797465206b;
    @(negedge clk);
    key   = k1;
    start = 1'b1;
    wait_fin(cyc);
    chk("held latency", 128'(cyc), 128'd11);
    repeat (8) @(posedge clk);
    #1 chk("held finish", 128'(finish), 128'h1);
    chk("held rk0", out[1407:1280], k1);
    chk("held rk6", out[639:512], expand(k1)[639:512]);
    chk_sched("held", k1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1 chk("held drop", 128'(finish), 128'h0);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key   = k1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = ~k1;
    wait_fin(cyc);
    chk("midrun latency", 128'(cyc), 128'd8);
    chk_sched("midrun", k1);
    @(negedge clk);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    key   = k1;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("abort");
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run("restart", k1);
    for (int i = 0; i < 6; i++) begin
      k2 = {$urandom, $urandom, $urandom, $urandom};
      run($sformatf("rnd%0d", i), k2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
